// File: rtl/red_pkg.sv
// Shared types for the red pipelined execute datapath: ALU opcodes, result-select
// encodings and the packed EX/MEM and MEM/WB pipeline register layouts.
package red_pkg;

   localparam int RED_DATA_W  = 32;
   localparam int RED_REG_AW  = 5;
   localparam int RED_DMEM_AW = 10;

   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_AND = 3'b010,
      ALU_OR  = 3'b011,
      ALU_XOR = 3'b100,
      ALU_SLT = 3'b101,
      ALU_SLL = 3'b110,
      ALU_SRL = 3'b111
   } alu_op_e;

   localparam logic [1:0] RES_ALU  = 2'b00;
   localparam logic [1:0] RES_LOAD = 2'b01;
   localparam logic [1:0] RES_PC4  = 2'b10;

   // Field widths follow the package constants; the top's width parameters default to them.
   typedef struct packed {
      logic                   vld;
      logic                   reg_write;
      logic                   mem_write;
      logic                   is_load;
      logic [RED_REG_AW-1:0]  rd;
      logic [RED_DMEM_AW-1:0] addr;
      logic [RED_DATA_W-1:0]  result;
      logic [RED_DATA_W-1:0]  st_dat;
      logic                   zero;
      logic [RED_DATA_W-1:0]  pc_target;
   } ex_mem_t;

   typedef struct packed {
      logic                  vld;
      logic [RED_REG_AW-1:0] rd;
      logic [RED_DATA_W-1:0] dat;
   } mem_wb_t;

endpackage

// File: rtl/red_alu.sv
// Combinational ALU for the execute stage; zero latency, no flow control.
// Shift amount is the low clog2(DATA_WIDTH) bits of b; all arithmetic wraps.
module red_alu
   import red_pkg::*;
#(
   parameter int DATA_WIDTH = RED_DATA_W
) (
   input  alu_op_e               op,
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   output logic [DATA_WIDTH-1:0] result,
   output logic                  zero
);

   localparam int SHW = $clog2(DATA_WIDTH);

   logic [SHW-1:0] shamt;
   assign shamt = b[SHW-1:0];

   always_comb begin
      result = '0;
      case (op)
         ALU_ADD: result = a + b;
         ALU_SUB: result = a - b;
         ALU_AND: result = a & b;
         ALU_OR:  result = a | b;
         ALU_XOR: result = a ^ b;
         ALU_SLT: result[0] = ($signed(a) < $signed(b));
         ALU_SLL: result = a << shamt;
         ALU_SRL: result = a >> shamt;
      endcase
   end

   assign zero = (result == '0);

endmodule

// File: rtl/red_pipe_datapath.sv
// Three-stage EX/MEM/WB datapath: branch result 1 cycle after issue, retire 2 cycles after.
// in_ready drops for one cycle on a load-use hazard (bubble inserted) and while rst is high.
module red_pipe_datapath
   import red_pkg::*;
#(
   parameter int DATA_WIDTH      = RED_DATA_W,
   parameter int REG_ADDR_WIDTH  = RED_REG_AW,
   parameter int DMEM_ADDR_WIDTH = RED_DMEM_AW,
   parameter int A0_INDEX        = 10
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [DATA_WIDTH-1:0]     imm_op,
   input  logic                      reg_write,
   input  logic [2:0]                alu_ctrl,
   input  logic                      alu_src,
   input  logic [REG_ADDR_WIDTH-1:0] rs1,
   input  logic [REG_ADDR_WIDTH-1:0] rs2,
   input  logic [REG_ADDR_WIDTH-1:0] rd,
   input  logic                      mem_write,
   input  logic [1:0]                result_src,
   input  logic [DATA_WIDTH-1:0]     pc,
   input  logic [DATA_WIDTH-1:0]     pc_plus4,
   input  logic                      jalr_ctrl,
   output logic                      br_valid,
   output logic                      zero,
   output logic [DATA_WIDTH-1:0]     pc_target,
   output logic                      wb_valid,
   output logic [REG_ADDR_WIDTH-1:0] wb_rd,
   output logic [DATA_WIDTH-1:0]     wb_data,
   output logic [DATA_WIDTH-1:0]     a0
);

   localparam int NREG       = 2 ** REG_ADDR_WIDTH;
   localparam int DMEM_DEPTH = 2 ** DMEM_ADDR_WIDTH;

   ex_mem_t ex_mem_q, ex_mem_d;
   mem_wb_t mem_wb_q, mem_wb_d;

   logic [NREG-1:0][DATA_WIDTH-1:0] rf_q, rf_d;
   logic [DATA_WIDTH-1:0]           dmem_mem [DMEM_DEPTH];

   logic [DATA_WIDTH-1:0] rs1_val, rs2_val, op2, alu_res;
   logic                  alu_zero;
   logic                  load_use, issue;

   // The register file returns pre-write data, so MEM/WB must be forwarded as well as EX/MEM.
   function automatic logic [DATA_WIDTH-1:0] read_operand(input logic [REG_ADDR_WIDTH-1:0] ra);
      if (ra == '0)
         return '0;
      if (ex_mem_q.vld && ex_mem_q.reg_write && (ex_mem_q.rd == ra))
         return ex_mem_q.result;
      if (mem_wb_q.vld && (mem_wb_q.rd == ra))
         return mem_wb_q.dat;
      return rf_q[ra];
   endfunction

   always_comb begin
      rs1_val = read_operand(rs1);
      rs2_val = read_operand(rs2);
      op2     = alu_src ? imm_op : rs2_val;
   end

   assign load_use = ex_mem_q.vld && ex_mem_q.is_load && (ex_mem_q.rd != '0) &&
                     ((ex_mem_q.rd == rs1) || (ex_mem_q.rd == rs2));
   assign in_ready = !rst && !load_use;
   assign issue    = in_valid && in_ready;

   red_alu #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_alu (
      .op     (alu_op_e'(alu_ctrl)),
      .a      (rs1_val),
      .b      (op2),
      .result (alu_res),
      .zero   (alu_zero)
   );

   always_comb begin
      ex_mem_d = '0;
      if (issue) begin
         ex_mem_d.vld       = 1'b1;
         ex_mem_d.reg_write = reg_write;
         ex_mem_d.mem_write = mem_write;
         ex_mem_d.is_load   = (result_src == RES_LOAD);
         ex_mem_d.rd        = rd;
         ex_mem_d.addr      = alu_res[DMEM_ADDR_WIDTH+1:2];
         ex_mem_d.result    = ((result_src & RES_PC4) != 2'b00) ? pc_plus4 : alu_res;
         ex_mem_d.st_dat    = rs2_val;
         ex_mem_d.zero      = alu_zero;
         ex_mem_d.pc_target = jalr_ctrl ? alu_res : (pc + imm_op);
      end
   end

   always_comb begin
      mem_wb_d     = '0;
      mem_wb_d.vld = ex_mem_q.vld && ex_mem_q.reg_write;
      mem_wb_d.rd  = ex_mem_q.rd;
      mem_wb_d.dat = ex_mem_q.is_load ? dmem_mem[ex_mem_q.addr] : ex_mem_q.result;
   end

   always_comb begin
      rf_d = rf_q;
      if (mem_wb_q.vld && (mem_wb_q.rd != '0))
         rf_d[mem_wb_q.rd] = mem_wb_q.dat;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_mem_q <= '0;
         mem_wb_q <= '0;
         rf_q     <= '0;
      end else begin
         ex_mem_q <= ex_mem_d;
         mem_wb_q <= mem_wb_d;
         rf_q     <= rf_d;
      end
   end

   // Data memory contents survive reset; only the store strobe is gated.
   always_ff @(posedge clk) begin
      if (!rst && ex_mem_q.vld && ex_mem_q.mem_write)
         dmem_mem[ex_mem_q.addr] <= ex_mem_q.st_dat;
   end

   assign br_valid  = ex_mem_q.vld;
   assign zero      = ex_mem_q.zero;
   assign pc_target = ex_mem_q.pc_target;
   assign wb_valid  = mem_wb_q.vld;
   assign wb_rd     = mem_wb_q.rd;
   assign wb_data   = mem_wb_q.dat;
   assign a0        = rf_q[A0_INDEX];

endmodule

// File: tb/tb_red_pipe_datapath.sv
// Self-checking bench: directed program plus random instruction stream against an
// in-order architectural model (register array, word memory, expected retire queues).
module tb_red_pipe_datapath;
   import red_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] imm_op = '0;
   logic        reg_write = 1'b0;
   logic [2:0]  alu_ctrl = '0;
   logic        alu_src = 1'b0;
   logic [4:0]  rs1 = '0, rs2 = '0, rd = '0;
   logic        mem_write = 1'b0;
   logic [1:0]  result_src = '0;
   logic [31:0] pc = '0, pc_plus4 = '0;
   logic        jalr_ctrl = 1'b0;
   logic        br_valid, zero, wb_valid;
   logic [31:0] pc_target, wb_data, a0;
   logic [4:0]  wb_rd;

   red_pipe_datapath dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .imm_op(imm_op), .reg_write(reg_write), .alu_ctrl(alu_ctrl), .alu_src(alu_src),
      .rs1(rs1), .rs2(rs2), .rd(rd), .mem_write(mem_write), .result_src(result_src),
      .pc(pc), .pc_plus4(pc_plus4), .jalr_ctrl(jalr_ctrl),
      .br_valid(br_valid), .zero(zero), .pc_target(pc_target),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .a0(a0)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] imm;
      logic        rw;
      logic [2:0]  op;
      logic        src;
      logic [4:0]  rs1, rs2, rd;
      logic        mw;
      logic [1:0]  rsrc;
      logic        jalr;
      logic [31:0] pc;
   } instr_t;
   typedef struct { int due; logic zero; logic [31:0] tgt; } br_exp_t;
   typedef struct { int due; logic [4:0] rd; logic [31:0] dat; } wb_exp_t;

   br_exp_t     brq[$];
   wb_exp_t     wbq[$];
   logic [31:0] R [32];
   logic [31:0] M [1024];
   logic [31:0] exp_a0 = '0;
   instr_t      last;
   int          last_at = -10;
   int          cyc = 0;
   int          n_vec = 0, n_err = 0;
   bit          mon_on = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic instr_t mk(logic [2:0] op, logic [4:0] d, logic [4:0] s1, logic [4:0] s2,
                                 logic [31:0] imm, logic src, logic rw, logic mw,
                                 logic [1:0] rsrc, logic jalr, logic [31:0] ipc);
      instr_t i;
      i.op = op; i.rd = d; i.rs1 = s1; i.rs2 = s2; i.imm = imm; i.src = src;
      i.rw = rw; i.mw = mw; i.rsrc = rsrc; i.jalr = jalr; i.pc = ipc;
      return i;
   endfunction

   function automatic instr_t addi(logic [4:0] d, logic [4:0] s1, logic [31:0] imm);
      return mk(ALU_ADD, d, s1, 5'd0, imm, 1'b1, 1'b1, 1'b0, RES_ALU, 1'b0, 32'd0);
   endfunction
   function automatic instr_t alu_rr(logic [2:0] op, logic [4:0] d, logic [4:0] s1, logic [4:0] s2);
      return mk(op, d, s1, s2, 32'd0, 1'b0, 1'b1, 1'b0, RES_ALU, 1'b0, 32'd0);
   endfunction
   function automatic instr_t lw(logic [4:0] d, logic [4:0] s1, logic [31:0] imm);
      return mk(ALU_ADD, d, s1, 5'd0, imm, 1'b1, 1'b1, 1'b0, RES_LOAD, 1'b0, 32'd0);
   endfunction
   function automatic instr_t sw(logic [4:0] s2, logic [4:0] s1, logic [31:0] imm);
      return mk(ALU_ADD, 5'd0, s1, s2, imm, 1'b1, 1'b0, 1'b1, RES_ALU, 1'b0, 32'd0);
   endfunction

   function automatic logic [31:0] ref_alu(logic [2:0] op, logic [31:0] a, logic [31:0] b);
      case (op)
         3'd0: return a + b;
         3'd1: return a - b;
         3'd2: return a & b;
         3'd3: return a | b;
         3'd4: return a ^ b;
         3'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         3'd6: return a << b[4:0];
         default: return a >> b[4:0];
      endcase
   endfunction

   function automatic logic [4:0] pick_reg();
      int r = $urandom_range(0, 8);
      return (r == 8) ? 5'd10 : 5'(r);
   endfunction

   // Executes one instruction in program order and records what the pipeline must show.
   task automatic exec(input instr_t i);
      logic [31:0] a, rb, y, res;
      br_exp_t be;
      wb_exp_t we;
      a   = (i.rs1 == 0) ? 32'd0 : R[i.rs1];
      rb  = (i.rs2 == 0) ? 32'd0 : R[i.rs2];
      y   = ref_alu(i.op, a, i.src ? i.imm : rb);
      res = i.rsrc[1] ? i.pc + 32'd4 : ((i.rsrc == 2'b01) ? M[y[11:2]] : y);
      if (i.mw) M[y[11:2]] = rb;
      if (i.rw && i.rd != 0) R[i.rd] = res;
      be.due = cyc; be.zero = (y == 0); be.tgt = i.jalr ? y : i.pc + i.imm;
      brq.push_back(be);
      if (i.rw) begin
         we.due = cyc + 1; we.rd = i.rd; we.dat = res;
         wbq.push_back(we);
      end
      last = i;
      last_at = cyc;
   endtask

   task automatic issue(input instr_t i, output int stalls);
      logic rdy, exp_rdy;
      bit   done;
      stalls = 0;
      done = 1'b0;
      @(negedge clk);
      in_valid = 1'b1; imm_op = i.imm; reg_write = i.rw; alu_ctrl = i.op; alu_src = i.src;
      rs1 = i.rs1; rs2 = i.rs2; rd = i.rd; mem_write = i.mw; result_src = i.rsrc;
      pc = i.pc; pc_plus4 = i.pc + 32'd4; jalr_ctrl = i.jalr;
      for (int t = 0; t < 4 && !done; t++) begin
         #1;
         exp_rdy = !(last_at == cyc && last.rsrc == 2'b01 && last.rd != 0 &&
                     (last.rd == i.rs1 || last.rd == i.rs2));
         chk("in_ready", in_ready, exp_rdy);
         rdy = in_ready;
         @(posedge clk);
         #1;
         if (rdy) begin
            exec(i);
            done = 1'b1;
         end else begin
            stalls++;
            @(negedge clk);
         end
      end
      chk("accepted", done, 1);
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      in_valid = 1'b0;
      brq.delete();
      wbq.delete();
      for (int r = 0; r < 32; r++) R[r] = '0;
      exp_a0 = '0;
      last_at = -10;
      #1;
      chk("rdy_in_rst", in_ready, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_br_valid", br_valid, 0);
      chk("rst_zero", zero, 0);
      chk("rst_pc_target", pc_target, 0);
      chk("rst_wb_valid", wb_valid, 0);
      chk("rst_wb_rd", wb_rd, 0);
      chk("rst_wb_data", wb_data, 0);
      chk("rst_a0", a0, 0);
      rst = 1'b0;
      #1;
      chk("rdy_after_rst", in_ready, 1);
      mon_on = 1'b1;
   endtask

   always begin
      @(posedge clk);
      #2;
      if (mon_on) begin
         chk("a0", a0, exp_a0);
         if (brq.size() != 0 && brq[0].due == cyc) begin
            chk("br_valid", br_valid, 1);
            chk("zero", zero, brq[0].zero);
            chk("pc_target", pc_target, brq[0].tgt);
            void'(brq.pop_front());
         end else
            chk("br_idle", br_valid, 0);
         if (wbq.size() != 0 && wbq[0].due == cyc) begin
            chk("wb_valid", wb_valid, 1);
            chk("wb_rd", wb_rd, wbq[0].rd);
            chk("wb_data", wb_data, wbq[0].dat);
            if (wbq[0].rd == 5'd10) exp_a0 = wbq[0].dat;
            void'(wbq.pop_front());
         end else
            chk("wb_idle", wb_valid, 0);
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1);
   end

   initial begin
      instr_t ins;
      int     st;
      int     kind;
      for (int r = 0; r < 32; r++) R[r] = '0;
      do_reset();

      issue(addi(5'd1, 5'd0, 32'd5), st);
      issue(alu_rr(ALU_ADD, 5'd2, 5'd1, 5'd1), st);
      chk("stall_fwd", st, 0);
      issue(sw(5'd2, 5'd0, 32'd8), st);
      issue(lw(5'd3, 5'd0, 32'd8), st);
      issue(alu_rr(ALU_ADD, 5'd4, 5'd3, 5'd3), st);
      chk("stall_load_use", st, 1);
      issue(addi(5'd0, 5'd0, 32'd7), st);
      issue(alu_rr(ALU_ADD, 5'd5, 5'd0, 5'd0), st);
      issue(addi(5'd7, 5'd0, 32'h100), st);
      issue(mk(ALU_ADD, 5'd8, 5'd7, 5'd0, 32'h20, 1'b1, 1'b1, 1'b0, RES_PC4, 1'b1, 32'h40), st);
      issue(addi(5'd6, 5'd0, 32'h33), st);
      issue(mk(ALU_SUB, 5'd0, 5'd6, 5'd6, 32'hFFFF_FFF8, 1'b0, 1'b0, 1'b0, RES_ALU, 1'b0, 32'h80), st);
      issue(addi(5'd10, 5'd0, 32'd9), st);
      do_reset();
      issue(lw(5'd11, 5'd0, 32'd8), st);
      issue(alu_rr(ALU_ADD, 5'd12, 5'd2, 5'd0), st);
      idle(3);

      for (int r = 1; r <= 10; r++) issue(addi(5'(r), 5'd0, $urandom), st);
      for (int k = 0; k < 16; k++) issue(sw(pick_reg(), 5'd0, 32'(4 * k)), st);

      for (int n = 0; n < 400; n++) begin
         kind = $urandom_range(0, 9);
         case (kind)
            0, 1, 2: ins = alu_rr(3'($urandom_range(0, 7)), pick_reg(), pick_reg(), pick_reg());
            3, 4:    ins = mk(3'($urandom_range(0, 7)), pick_reg(), pick_reg(), pick_reg(), $urandom,
                              1'b1, 1'b1, 1'b0, RES_ALU, 1'b0, $urandom & 32'hFFFF_FFFC);
            5:       ins = lw(pick_reg(), 5'd0, 32'(4 * $urandom_range(0, 15)));
            6:       ins = sw(pick_reg(), 5'd0, 32'(4 * $urandom_range(0, 15)));
            7:       ins = mk(3'($urandom_range(0, 7)), pick_reg(), pick_reg(), pick_reg(), $urandom,
                              1'($urandom_range(0, 1)), 1'b1, 1'b0, 2'($urandom_range(2, 3)),
                              1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC);
            8:       ins = mk(ALU_SUB, 5'd0, pick_reg(), pick_reg(), $urandom, 1'b0, 1'b0, 1'b0,
                              RES_ALU, 1'b0, $urandom & 32'hFFFF_FFFC);
            default: ins = addi(5'd0, 5'd0, 32'd0);
         endcase
         if (kind == 9) idle(1);
         else issue(ins, st);
      end

      idle(4);
      chk("drain", 32'(brq.size() + wbq.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
